// File: rtl/pkt_buffer_service.sv
// Flit buffer responder: one write and one read per cycle, write-first collision
// bypass, fixed-latency read-return pipeline and 32-bit access statistics.

package pkt_buffer_pkg;
  localparam int PKTBUF_AWIDTH = 6;
  typedef logic [31:0] flit_t;
endpackage

module pkt_buffer_service
  import pkt_buffer_pkg::*;
#(
  parameter int AWIDTH       = PKTBUF_AWIDTH,
  parameter int READ_LATENCY = 2
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic [AWIDTH-1:0] pkt_buffer_writeaddress,
  input  logic              pkt_buffer_write,
  input  flit_t             pkt_buffer_writedata,
  input  logic [AWIDTH-1:0] pkt_buffer_readaddress,
  input  logic              pkt_buffer_read,
  output logic              pkt_buffer_readvalid,
  output flit_t             pkt_buffer_readdata,
  output logic [31:0]       stats_wr_flits,
  output logic [31:0]       stats_rd_flits,
  output logic [31:0]       stats_collisions
);

  localparam int DEPTH = 2 ** AWIDTH;

  if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
    $fatal(1, "pkt_buffer_service: READ_LATENCY must be in 1..4");
  end

  // Flit storage is deliberately left out of reset so contents survive Rst_n.
  flit_t mem_q [DEPTH];

  always_ff @(posedge Clk) begin
    if (pkt_buffer_write) begin
      mem_q[pkt_buffer_writeaddress] <= pkt_buffer_writedata;
    end
  end

  logic  collision;
  flit_t rd_flit;

  assign collision = pkt_buffer_read && pkt_buffer_write &&
                     (pkt_buffer_readaddress == pkt_buffer_writeaddress);
  assign rd_flit   = collision ? pkt_buffer_writedata : mem_q[pkt_buffer_readaddress];

  logic [READ_LATENCY-1:0] vld_q, vld_d;
  flit_t                   dat_q [READ_LATENCY];
  flit_t                   dat_d [READ_LATENCY];
  logic [31:0]             stats_wr_q, stats_wr_d;
  logic [31:0]             stats_rd_q, stats_rd_d;
  logic [31:0]             stats_col_q, stats_col_d;

  // Data in each stage only moves when a valid arrives, so the last stage holds
  // the most recently returned flit while no read is completing.
  always_comb begin
    vld_d[0] = pkt_buffer_read;
    dat_d[0] = pkt_buffer_read ? rd_flit : dat_q[0];
    for (int i = 1; i < READ_LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      dat_d[i] = vld_q[i-1] ? dat_q[i-1] : dat_q[i];
    end
    stats_wr_d  = stats_wr_q + 32'(pkt_buffer_write);
    stats_rd_d  = stats_rd_q + 32'(pkt_buffer_read);
    stats_col_d = stats_col_q + 32'(collision);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      vld_q       <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        dat_q[i] <= '0;
      end
      stats_wr_q  <= '0;
      stats_rd_q  <= '0;
      stats_col_q <= '0;
    end else begin
      vld_q       <= vld_d;
      for (int i = 0; i < READ_LATENCY; i++) begin
        dat_q[i] <= dat_d[i];
      end
      stats_wr_q  <= stats_wr_d;
      stats_rd_q  <= stats_rd_d;
      stats_col_q <= stats_col_d;
    end
  end

  assign pkt_buffer_readvalid = vld_q[READ_LATENCY-1];
  assign pkt_buffer_readdata  = dat_q[READ_LATENCY-1];
  assign stats_wr_flits       = stats_wr_q;
  assign stats_rd_flits       = stats_rd_q;
  assign stats_collisions     = stats_col_q;

endmodule

// File: tb/tb_pkt_buffer_service.sv
// Bench for pkt_buffer_service: three instances (latency 1, 2, 4) share stimulus
// and are compared every cycle against an issue-history reference model.

module tb_pkt_buffer_service;
  import pkt_buffer_pkg::*;

  localparam int AW    = PKTBUF_AWIDTH;
  localparam int DEPTH = 1 << AW;
  localparam int NL    = 3;

  logic          Clk = 1'b0;
  logic          Rst_n = 1'b0;
  logic [AW-1:0] wa = '0;
  logic [AW-1:0] ra = '0;
  logic          wr = 1'b0;
  logic          rd = 1'b0;
  flit_t         wd = '0;

  logic          rv   [NL];
  flit_t         rdat [NL];
  logic [31:0]   swr  [NL];
  logic [31:0]   srd  [NL];
  logic [31:0]   scol [NL];

  pkt_buffer_service #(.AWIDTH(AW), .READ_LATENCY(1)) dut_l1 (
    .Clk(Clk), .Rst_n(Rst_n),
    .pkt_buffer_writeaddress(wa), .pkt_buffer_write(wr), .pkt_buffer_writedata(wd),
    .pkt_buffer_readaddress(ra), .pkt_buffer_read(rd),
    .pkt_buffer_readvalid(rv[0]), .pkt_buffer_readdata(rdat[0]),
    .stats_wr_flits(swr[0]), .stats_rd_flits(srd[0]), .stats_collisions(scol[0])
  );

  pkt_buffer_service #(.AWIDTH(AW), .READ_LATENCY(2)) dut_l2 (
    .Clk(Clk), .Rst_n(Rst_n),
    .pkt_buffer_writeaddress(wa), .pkt_buffer_write(wr), .pkt_buffer_writedata(wd),
    .pkt_buffer_readaddress(ra), .pkt_buffer_read(rd),
    .pkt_buffer_readvalid(rv[1]), .pkt_buffer_readdata(rdat[1]),
    .stats_wr_flits(swr[1]), .stats_rd_flits(srd[1]), .stats_collisions(scol[1])
  );

  pkt_buffer_service #(.AWIDTH(AW), .READ_LATENCY(4)) dut_l4 (
    .Clk(Clk), .Rst_n(Rst_n),
    .pkt_buffer_writeaddress(wa), .pkt_buffer_write(wr), .pkt_buffer_writedata(wd),
    .pkt_buffer_readaddress(ra), .pkt_buffer_read(rd),
    .pkt_buffer_readvalid(rv[2]), .pkt_buffer_readdata(rdat[2]),
    .stats_wr_flits(swr[2]), .stats_rd_flits(srd[2]), .stats_collisions(scol[2])
  );

  always #5 Clk = ~Clk;

  // Reference model: memory image plus the history of read issues; a latency-L
  // buffer shows the issue made L-1 edges before the latest one.
  flit_t       mem_m   [DEPTH];
  bit          known_m [DEPTH];
  bit          hv [1:4];
  flit_t       hd [1:4];
  bit          hk [1:4];
  bit          ov [NL];
  flit_t       od [NL];
  bit          okn [NL];
  logic [31:0] wr_m, rd_m, col_m;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : (i == 1) ? 2 : 4;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int j = 1; j <= 4; j++) begin
      hv[j] = 1'b0;
      hd[j] = '0;
      hk[j] = 1'b1;
    end
    for (int i = 0; i < NL; i++) begin
      ov[i]  = 1'b0;
      od[i]  = '0;
      okn[i] = 1'b1;
    end
    wr_m  = '0;
    rd_m  = '0;
    col_m = '0;
  endtask

  task automatic model_edge();
    bit    col;
    flit_t idata;
    bit    iknown;
    col    = wr && rd && (wa == ra);
    idata  = col ? wd : mem_m[ra];
    iknown = col || known_m[ra];
    for (int j = 4; j >= 2; j--) begin
      hv[j] = hv[j-1];
      hd[j] = hd[j-1];
      hk[j] = hk[j-1];
    end
    hv[1] = rd;
    hd[1] = idata;
    hk[1] = iknown;
    for (int i = 0; i < NL; i++) begin
      ov[i] = hv[lat_of(i)];
      if (hv[lat_of(i)]) begin
        od[i]  = hd[lat_of(i)];
        okn[i] = hk[lat_of(i)];
      end
    end
    if (wr) begin
      mem_m[wa]   = wd;
      known_m[wa] = 1'b1;
    end
    wr_m  = wr_m + (wr ? 32'd1 : 32'd0);
    rd_m  = rd_m + (rd ? 32'd1 : 32'd0);
    col_m = col_m + (col ? 32'd1 : 32'd0);
  endtask

  task automatic check_all();
    for (int i = 0; i < NL; i++) begin
      checkOutput($sformatf("readvalid_L%0d", lat_of(i)), 32'(rv[i]), 32'(ov[i]));
      if (okn[i]) checkOutput($sformatf("readdata_L%0d", lat_of(i)), rdat[i], od[i]);
      checkOutput($sformatf("stats_wr_L%0d", lat_of(i)), swr[i], wr_m);
      checkOutput($sformatf("stats_rd_L%0d", lat_of(i)), srd[i], rd_m);
      checkOutput($sformatf("stats_col_L%0d", lat_of(i)), scol[i], col_m);
    end
  endtask

  // Called at a falling edge: drive one cycle of requests, step the model on
  // the rising edge, then compare on the next falling edge.
  task automatic applyStimulus(input bit w, input int waddr, input logic [31:0] wdata,
                               input bit r, input int raddr);
    wr = w;
    wa = AW'(waddr);
    wd = wdata;
    rd = r;
    ra = AW'(raddr);
    @(posedge Clk);
    model_edge();
    @(negedge Clk);
    check_all();
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 0, '0, 1'b0, 0);
  endtask

  task automatic do_reset(input int n);
    wr    = 1'b0;
    rd    = 1'b0;
    Rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    repeat (n) begin
      @(posedge Clk);
      @(negedge Clk);
      check_all();
    end
    Rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_m[i]   = '0;
      known_m[i] = 1'b0;
    end
    model_reset();
    @(negedge Clk);
    do_reset(2);

    // Write 0..7 then read them back-to-back
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, i, 32'hA000 + 32'(i), 1'b0, 0);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 0, '0, 1'b1, i);
    idle(5);
    checkOutput("wb_wr_flits", swr[1], 32'd8);
    checkOutput("wb_rd_flits", srd[1], 32'd8);
    checkOutput("wb_last_data", rdat[1], 32'hA007);

    // Same-cycle collision returns the new data
    applyStimulus(1'b1, 5, 32'h11, 1'b0, 0);
    applyStimulus(1'b1, 5, 32'h22, 1'b1, 5);
    idle(4);
    checkOutput("col_count", scol[1], 32'd1);
    for (int i = 0; i < NL; i++) checkOutput($sformatf("col_data_L%0d", lat_of(i)), rdat[i], 32'h22);

    // Write inside the return window does not disturb the in-flight read
    applyStimulus(1'b1, 9, 32'h33, 1'b0, 0);
    applyStimulus(1'b0, 0, '0, 1'b1, 9);
    applyStimulus(1'b1, 9, 32'h44, 1'b0, 0);
    idle(4);
    for (int i = 0; i < NL; i++) checkOutput($sformatf("window_old_L%0d", lat_of(i)), rdat[i], 32'h33);
    applyStimulus(1'b0, 0, '0, 1'b1, 9);
    idle(4);
    for (int i = 0; i < NL; i++) checkOutput($sformatf("window_new_L%0d", lat_of(i)), rdat[i], 32'h44);

    // Reset with reads in flight; memory survives
    applyStimulus(1'b1, 0, 32'h55, 1'b0, 0);
    for (int i = 1; i <= 3; i++) applyStimulus(1'b0, 0, '0, 1'b1, i);
    do_reset(2);
    checkOutput("rst_rd_flits", srd[2], 32'd0);
    applyStimulus(1'b0, 0, '0, 1'b1, 0);
    idle(4);
    for (int i = 0; i < NL; i++) checkOutput($sformatf("rst_mem_L%0d", lat_of(i)), rdat[i], 32'h55);

    // Read counter wraps modulo 2^32
    force dut_l1.stats_rd_q = 32'hFFFF_FFFF;
    force dut_l2.stats_rd_q = 32'hFFFF_FFFF;
    force dut_l4.stats_rd_q = 32'hFFFF_FFFF;
    #1;
    release dut_l1.stats_rd_q;
    release dut_l2.stats_rd_q;
    release dut_l4.stats_rd_q;
    rd_m = 32'hFFFF_FFFF;
    applyStimulus(1'b0, 0, '0, 1'b1, 0);
    for (int i = 0; i < NL; i++) checkOutput($sformatf("wrap_rd_L%0d", lat_of(i)), srd[i], 32'd0);
    idle(4);

    // Randomized traffic with occasional mid-flight resets
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset($urandom_range(1, 3));
      end else begin
        int narrow;
        narrow = $urandom_range(0, 1);
        applyStimulus(1'($urandom_range(0, 1)),
                      narrow ? $urandom_range(0, 7) : $urandom_range(0, DEPTH - 1),
                      $urandom,
                      1'($urandom_range(0, 1)),
                      narrow ? $urandom_range(0, 7) : $urandom_range(0, DEPTH - 1));
      end
    end
    idle(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pkt_buffer_service.md
# pkt_buffer_service

Packet-buffer responder serving the write and read request ports of the reassembler pipeline. It accepts flit writes from the input-compaction stage and flit reads from the data mover. It returns read data with a fixed pipelined latency and a `readvalid` strobe. It sits between the reassembler and the on-chip flit memory and owns read/write collision semantics, the read-return pipeline and the buffer access statistics.

## Interface
Parameters:
- `AWIDTH`, default `PKTBUF_AWIDTH`: flit address width; memory depth is `2**AWIDTH` flits.
- `READ_LATENCY`, default 2: cycles from read request to `readvalid`. Legal range 1..4; anything else is a fatal elaboration error.

Ports:
- `Clk`, in, 1: the single clock.
- `Rst_n`, in, 1: asynchronous, active-low reset.
- `pkt_buffer_writeaddress`, in, `AWIDTH`: write address.
- `pkt_buffer_write`, in, 1: write strobe, one flit per cycle.
- `pkt_buffer_writedata`, in, `$bits(flit_t)`: write flit.
- `pkt_buffer_readaddress`, in, `AWIDTH`: read address.
- `pkt_buffer_read`, in, 1: read strobe, one request per cycle.
- `pkt_buffer_readvalid`, out, 1: read data valid.
- `pkt_buffer_readdata`, out, `flit_t`: returned flit.
- `stats_wr_flits`, out, 32: count of accepted writes.
- `stats_rd_flits`, out, 32: count of accepted reads.
- `stats_collisions`, out, 32: count of same-cycle, same-address read+write events.

## Operation
- There is no backpressure. Every asserted `write` and every asserted `read` is accepted in the cycle it is sampled. Write and read proceed independently in the same cycle.
- Write: on a rising edge with `write=1`, `mem[writeaddress] <= writedata`.
- Read issue: on a rising edge with `read=1`, the flit at `readaddress` is captured into pipeline stage 1, together with valid=1.
- Collision, where `read=1`, `write=1` and the addresses are equal in the same cycle:
  - The read returns the new `writedata` (write-first bypass).
  - `stats_collisions` increments.
- A write to an address during a read's return window (after issue, before `readvalid`) does not alter that read's returned data.
- Return pipeline:
  - Stages 1..`READ_LATENCY` are registered data+valid pairs.
  - The last stage drives `readvalid` and `readdata`.
  - Requests on consecutive cycles return on consecutive cycles, in issue order.
- `readdata` holds its last value while `readvalid=0`. The consumer must ignore it in that state.
- Counters:
  - All counters are 32-bit, wrap modulo 2^32, and increment by at most 1 per cycle.
  - `stats_wr_flits` increments on `write`.
  - `stats_rd_flits` increments on `read`.
- Memory contents are not reset. A read of a never-written address returns an undefined flit, with `readvalid` still asserted.

## Timing
- Reset values:
  - `readvalid=0`.
  - `readdata` = all zeros.
  - All pipeline valids = 0.
  - All stats = 0.
- Reset is asynchronous. Asserting `Rst_n=0` mid-operation clears every in-flight read (no `readvalid` for them) and all counters. Memory is retained.
- The first edge after deassertion samples requests normally.
- Read latency: a request sampled at edge T produces `readvalid=1` in the cycle following edge T+`READ_LATENCY`-1. With the default latency of 2, a read sampled at edge 0 gives `readvalid` high after edge 1, for exactly one cycle per request.
- Write-to-read: a write at edge T is visible to a read sampled at edge T (bypass) or at any later edge.
- Throughput: one write plus one read per cycle, sustained, with no bubbles.
- Address wrap: addresses are used modulo `2**AWIDTH`; there is no bounds checking.

## Test plan
- Write/readback:
  - Stimulus: write flits with data=A+i to addresses 0..7 on consecutive cycles, then read 0..7 back-to-back.
  - Required: 8 consecutive `readvalid` cycles starting 2 cycles after the first read, returning A..A+7 in order, `stats_wr_flits=8`, `stats_rd_flits=8`.
- Collision:
  - Stimulus: pre-write 0x11 at address 5, then write 0x22 and read address 5 in the same cycle.
  - Required: returned flit is 0x22, `stats_collisions=1`.
- Write during return window:
  - Stimulus: address 9 holds 0x33; read 9 at edge T, then write 0x44 to 9 at edge T+1.
  - Required: returns 0x33; a subsequent read of 9 returns 0x44.
- Reset mid-flight:
  - Stimulus: issue reads on 3 consecutive cycles, assert `Rst_n=0` one cycle later for 2 cycles, then read address 0 (written before reset with 0x55).
  - Required: none of the 3 in-flight reads produce `readvalid`; all stats read 0; the post-reset read returns 0x55.
- Latency sweep:
  - Stimulus: repeat the first scenario with `READ_LATENCY` = 1 and 4.
  - Required: first `readvalid` arrives 1 and 4 cycles after the first read, respectively, with identical data.
- Counter wrap:
  - Stimulus: force `stats_rd_flits` to 0xFFFFFFFF, then issue one read.
  - Required: `stats_rd_flits` = 0.
